// File: rtl/execute_md.sv
// =============================================================================
// Module   : execute_md
// Brief    : Registered RV32IM execute stage (ALU, branch resolve, iterative mul/div)
// Revision : 1.0
// =============================================================================
`default_nettype none

module execute_md #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_THREADS   = 8,
    localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     valid_d,
    output logic                     ready_d,
    input  logic                     muldiv_d,
    input  logic                     reg_write_d,
    input  logic                     mem_write_d,
    input  logic                     jump_d,
    input  logic                     branch_d,
    input  logic [1:0]               res_src_d,
    input  logic [3:0]               alu_control_d,
    input  logic [2:0]               funct3_d,
    input  logic                     alu_src_a_d,
    input  logic                     alu_src_b_d,
    input  logic [DATA_WIDTH-1:0]    rd1_d,
    input  logic [DATA_WIDTH-1:0]    rd2_d,
    input  logic [DATA_WIDTH-1:0]    imm_val_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_d,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    input  logic [4:0]               rd_d,
    input  logic [BITS_THREADS-1:0]  tid_d,
    output logic                     valid_e,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     pc_src_e,
    output logic [1:0]               res_src_e,
    output logic [2:0]               funct3_e,
    output logic [DATA_WIDTH-1:0]    alu_result_e,
    output logic [DATA_WIDTH-1:0]    write_data_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [4:0]               rd_e,
    output logic [BITS_THREADS-1:0]  tid_e
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_start = c_cnt_w'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_accept;

    assign ready_d  = (r_state == ST_IDLE) & ~rst;
    assign w_accept = valid_d & ready_d & ~flush;

    // ---------------- ALU and branch condition ----------------
    logic [DATA_WIDTH-1:0] w_src_a;
    logic [DATA_WIDTH-1:0] w_src_b;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [c_cnt_w-1:0]    w_shamt;
    logic                  w_br_taken;

    assign w_src_a = alu_src_a_d ? DATA_WIDTH'(pc_d) : rd1_d;
    assign w_src_b = alu_src_b_d ? imm_val_d : rd2_d;
    assign w_shamt = w_src_b[c_cnt_w-1:0];

    always_comb begin
        w_alu_result = '0;
        case (alu_control_d)
            4'd0:    w_alu_result = w_src_a + w_src_b;
            4'd1:    w_alu_result = w_src_a - w_src_b;
            4'd2:    w_alu_result = w_src_a & w_src_b;
            4'd3:    w_alu_result = w_src_a | w_src_b;
            4'd4:    w_alu_result = w_src_a ^ w_src_b;
            4'd5:    w_alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            4'd6:    w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_src_a < w_src_b};
            4'd7:    w_alu_result = w_src_a << w_shamt;
            4'd8:    w_alu_result = w_src_a >> w_shamt;
            4'd9:    w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
            4'd10:   w_alu_result = w_src_b;
            default: w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (funct3_d)
            3'b000:  w_br_taken = (rd1_d == rd2_d);
            3'b001:  w_br_taken = (rd1_d != rd2_d);
            3'b100:  w_br_taken = ($signed(rd1_d) <  $signed(rd2_d));
            3'b101:  w_br_taken = ($signed(rd1_d) >= $signed(rd2_d));
            3'b110:  w_br_taken = (rd1_d <  rd2_d);
            3'b111:  w_br_taken = (rd1_d >= rd2_d);
            default: w_br_taken = 1'b0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && muldiv_d) begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = c_cnt_start;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                ST_FIN:  w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- Mul/div datapath ----------------
    // r_hi/r_lo hold product high/low for MUL and remainder/quotient for DIV.
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_mag_b;
    logic                    r_neg;
    logic                    r_rem_neg;
    logic                    r_div_zero;
    logic [2:0]              r_f3;
    logic [4:0]              r_rd;
    logic [BITS_THREADS-1:0] r_tid;
    logic                    r_reg_write;
    logic [1:0]              r_res_src;
    logic [DATA_WIDTH-1:0]   r_rd2;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;

    logic                    w_a_signed;
    logic                    w_b_signed;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_shifted;
    logic [DATA_WIDTH:0]     w_trial;

    assign w_a_signed = funct3_d[2] ? ~funct3_d[0] : ~(funct3_d[1] & funct3_d[0]);
    assign w_b_signed = funct3_d[2] ? ~funct3_d[0] : ~funct3_d[1];
    assign w_a_neg    = w_a_signed & rd1_d[DATA_WIDTH-1];
    assign w_b_neg    = w_b_signed & rd2_d[DATA_WIDTH-1];

    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
    assign w_shifted = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_mag_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_mag_b     <= '0;
            r_neg       <= 1'b0;
            r_rem_neg   <= 1'b0;
            r_div_zero  <= 1'b0;
            r_f3        <= '0;
            r_rd        <= '0;
            r_tid       <= '0;
            r_reg_write <= 1'b0;
            r_res_src   <= '0;
            r_rd2       <= '0;
            r_pc_plus4  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && muldiv_d) begin
                r_hi        <= '0;
                r_lo        <= w_a_neg ? -rd1_d : rd1_d;
                r_mag_b     <= w_b_neg ? -rd2_d : rd2_d;
                r_neg       <= w_a_neg ^ w_b_neg;
                r_rem_neg   <= w_a_neg;
                r_div_zero  <= (rd2_d == '0);
                r_f3        <= funct3_d;
                r_rd        <= rd_d;
                r_tid       <= tid_d;
                r_reg_write <= reg_write_d;
                r_res_src   <= res_src_d;
                r_rd2       <= rd2_d;
                r_pc_plus4  <= pc_plus4_d;
            end
        end else if (r_state == ST_BUSY) begin
            if (r_f3[2]) begin
                // Restoring step: keep the subtraction only when it does not borrow.
                if (!w_trial[DATA_WIDTH]) begin
                    r_hi <= w_trial[DATA_WIDTH-1:0];
                    r_lo <= {r_lo[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shifted[DATA_WIDTH-1:0];
                    r_lo <= {r_lo[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[DATA_WIDTH:1];
                r_lo <= {w_sum[0], r_lo[DATA_WIDTH-1:1]};
            end
        end
    end

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quot;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_md_result;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quot     = r_div_zero ? '1 : (r_neg ? -r_lo : r_lo);
    assign w_rem      = r_rem_neg ? -r_hi : r_hi;

    always_comb begin
        w_md_result = '0;
        if (r_f3[2]) begin
            w_md_result = r_f3[1] ? w_rem : w_quot;
        end else if (r_f3[1:0] == 2'b00) begin
            w_md_result = w_prod_fix[DATA_WIDTH-1:0];
        end else begin
            w_md_result = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // ---------------- Output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e      <= 1'b0;
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            pc_src_e     <= 1'b0;
            res_src_e    <= '0;
            funct3_e     <= '0;
            alu_result_e <= '0;
            write_data_e <= '0;
            pc_target_e  <= '0;
            pc_plus4_e   <= '0;
            rd_e         <= '0;
            tid_e        <= '0;
        end else begin
            valid_e <= 1'b0;
            if (w_accept && !muldiv_d) begin
                valid_e      <= 1'b1;
                reg_write_e  <= reg_write_d;
                mem_write_e  <= mem_write_d;
                pc_src_e     <= jump_d | (branch_d & w_br_taken);
                res_src_e    <= res_src_d;
                funct3_e     <= funct3_d;
                alu_result_e <= w_alu_result;
                write_data_e <= rd2_d;
                pc_target_e  <= ADDRESS_WIDTH'(w_alu_result);
                pc_plus4_e   <= pc_plus4_d;
                rd_e         <= rd_d;
                tid_e        <= tid_d;
            end else if (r_state == ST_FIN && !flush) begin
                valid_e      <= 1'b1;
                reg_write_e  <= r_reg_write;
                mem_write_e  <= 1'b0;
                pc_src_e     <= 1'b0;
                res_src_e    <= r_res_src;
                funct3_e     <= r_f3;
                alu_result_e <= w_md_result;
                write_data_e <= r_rd2;
                pc_target_e  <= ADDRESS_WIDTH'(w_md_result);
                pc_plus4_e   <= r_pc_plus4;
                rd_e         <= r_rd;
                tid_e        <= r_tid;
            end
        end
    end

endmodule

`default_nettype wire
